// File: rtl/y86_pipe_control.sv
// Pipeline control for the five-stage Y-86: stall/bubble selection, CC gating,
// run/stop state machine and saturating performance counters.
module y86_pipe_control #(
    parameter int unsigned CNT_W    = 32,
    parameter logic [3:0]  STAT_AOK = 4'b1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    input  logic [3:0]       W_icode,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [3:0]       stop_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic             state_dbg
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic lu, mp, rt, exc, retire;

    assign lu  = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign mp  = (E_icode == I_JXX) && !e_Cnd;
    assign rt  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign exc = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);
    assign retire = (W_stat == STAT_AOK) && (W_icode != I_HALT) && (W_icode != I_NOP);

    always_comb begin
        state_d  = state_q;
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        if (state_q == RUN) begin
            if (W_stat != STAT_AOK) state_d = STOP;
            F_stall  = lu | rt;
            D_stall  = lu;
            // A load-use stall outranks the ret bubble so D keeps the consumer.
            D_bubble = mp | (rt & !lu);
            E_bubble = mp | lu;
            M_bubble = exc;
            W_stall  = (W_stat != STAT_AOK);
            set_cc   = (E_icode == I_OPQ) & !exc;
        end else begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b1;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            stop_stat <= STAT_AOK;
            cyc_cnt   <= '0;
            ret_cnt   <= '0;
            lu_cnt    <= '0;
            mp_cnt    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RUN) begin
                if (state_d == STOP) stop_stat <= W_stat;
                cyc_cnt <= sat_inc(cyc_cnt);
                if (retire) ret_cnt <= sat_inc(ret_cnt);
                if (lu)     lu_cnt  <= sat_inc(lu_cnt);
                if (mp)     mp_cnt  <= sat_inc(mp_cnt);
            end
        end
    end

    assign halted    = (state_q == STOP);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_y86_pipe_control.sv
// Directed bench for y86_pipe_control: a combinational vector table applied
// in the reset cycle, then hand sequences for counters, ret walk and stop/reset.
module tb_y86_pipe_control;

    localparam logic [3:0] AOK = 4'b1000;
    localparam logic [3:0] ADR = 4'b0010;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat, W_icode;
    logic        e_Cnd;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [3:0]  stop_stat;
    logic [31:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt;
    logic        state_dbg;
    logic [6:0]  ctrl;

    int n_vec = 0;
    int n_err = 0;
    int exp_cyc = 0;
    int exp_lu = 0;
    int exp_mp = 0;
    int exp_ret = 0;
    bit stopped = 0;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    y86_pipe_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .halted(halted),
        .stop_stat(stop_stat), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt),
        .mp_cnt(mp_cnt), .state_dbg(state_dbg)
    );

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    assign ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};

    typedef struct {
        logic [3:0] d_icode, srca, srcb, e_icode, e_dstm;
        logic       cnd;
        logic [3:0] m_icode, mstat, wstat;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic benign();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1; E_dstM = 4'hF;
        e_Cnd = 1'b1; M_icode = 4'h1; m_stat = AOK; W_stat = AOK; W_icode = 4'h1;
    endtask

    task automatic step();
        if (!reset && !stopped) exp_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_cyc"}, cyc_cnt, exp_cyc);
        check({tag, "_lu"},  lu_cnt,  exp_lu);
        check({tag, "_mp"},  mp_cnt,  exp_mp);
        check({tag, "_ret"}, ret_cnt, exp_ret);
    endtask

    logic [31:0] cyc_frozen;

    initial begin
        tbl[0]  = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, AOK, AOK, 7'b0000000};
        tbl[1]  = '{4'h6, 4'hF, 4'h3, 4'h5, 4'h3, 1'b1, 4'h1, AOK, AOK, 7'b1101000};
        tbl[2]  = '{4'h6, 4'h4, 4'hF, 4'hB, 4'h4, 1'b1, 4'h1, AOK, AOK, 7'b1101000};
        tbl[3]  = '{4'h6, 4'hF, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, AOK, AOK, 7'b0000000};
        tbl[4]  = '{4'h6, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, AOK, AOK, 7'b0011000};
        tbl[5]  = '{4'h6, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, AOK, AOK, 7'b0000000};
        tbl[6]  = '{4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, AOK, AOK, 7'b1010000};
        tbl[7]  = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h9, AOK, AOK, 7'b1010000};
        tbl[8]  = '{4'h9, 4'hF, 4'h3, 4'h5, 4'h3, 1'b1, 4'h1, AOK, AOK, 7'b1101000};
        tbl[9]  = '{4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, AOK, AOK, 7'b0000001};
        tbl[10] = '{4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, ADR, AOK, 7'b0000100};
        tbl[11] = '{4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, AOK, ADR, 7'b0000110};
        tbl[12] = '{4'h6, 4'h2, 4'h4, 4'h5, 4'h3, 1'b1, 4'h1, AOK, AOK, 7'b0000000};

        reset = 1'b1;
        benign();
        step();
        step();
        check("rst_halted", halted, 0);
        check("rst_stop_stat", stop_stat, AOK);
        check("rst_state", state_dbg, 0);
        check_cnts("rst");

        // Combinational table, applied while reset holds the FSM in RUN.
        for (int i = 0; i < 13; i++) begin
            D_icode = tbl[i].d_icode; d_srcA = tbl[i].srca; d_srcB = tbl[i].srcb;
            E_icode = tbl[i].e_icode; E_dstM = tbl[i].e_dstm; e_Cnd = tbl[i].cnd;
            M_icode = tbl[i].m_icode; m_stat = tbl[i].mstat; W_stat = tbl[i].wstat;
            #2;
            check($sformatf("vec%0d_ctrl", i), ctrl, tbl[i].exp);
        end
        benign();
        step();
        check("tbl_state", state_dbg, 0);

        reset = 1'b0;
        step();
        step();
        check_cnts("run2");

        // Load-use: one stall cycle, counted once.
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3; D_icode = 4'h6;
        #1 check("lu_ctrl", ctrl, 7'b1101000);
        exp_lu++;
        step();
        benign();
        #1 check("lu_after", ctrl, 7'b0000000);
        check_cnts("lu");

        // Mispredict then taken jump.
        E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h6;
        #1 check("mp_ctrl", ctrl, 7'b0011000);
        exp_mp++;
        step();
        e_Cnd = 1'b1;
        #1 check("mp_taken", ctrl, 7'b0000000);
        step();
        check_cnts("mp");

        // ret walks D -> E -> M, then clears.
        benign(); D_icode = 4'h9;
        #1 check("ret_d", ctrl, 7'b1010000);
        step();
        benign(); E_icode = 4'h9;
        #1 check("ret_e", ctrl, 7'b1010000);
        step();
        benign(); M_icode = 4'h9;
        #1 check("ret_m", ctrl, 7'b1010000);
        step();
        benign();
        #1 check("ret_done", ctrl, 7'b0000000);

        // Retirement: two real instructions, one halt, bubbles ignored.
        W_icode = 4'h6; exp_ret++; step();
        W_icode = 4'h2; exp_ret++; step();
        W_icode = 4'h0; step();
        W_icode = 4'h1; step();
        check_cnts("retire");

        // Exception flows M -> W -> stop.
        benign(); E_icode = 4'h6; m_stat = ADR;
        #1 check("exc_m_ctrl", ctrl, 7'b0000100);
        step();
        benign(); W_stat = ADR; W_icode = 4'h3;
        #1 check("exc_w_ctrl", ctrl, 7'b0000110);
        check("exc_w_halted", halted, 0);
        step();
        stopped = 1;
        check("stop_halted", halted, 1);
        check("stop_stat", stop_stat, ADR);
        check("stop_state", state_dbg, 1);
        check_cnts("stop");
        cyc_frozen = cyc_cnt;
        benign(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; D_icode = 4'h9; W_icode = 4'h6;
        #1 check("stop_ctrl", ctrl, 7'b1101110);
        step(); step(); step();
        check("stop_cyc_frozen", cyc_cnt, cyc_frozen);
        check_cnts("stop_hold");
        check("stop_absorb", halted, 1);

        // Reset out of STOP, then counting resumes from zero.
        benign();
        reset = 1'b1;
        step();
        reset = 1'b0;
        stopped = 0;
        exp_cyc = 0; exp_lu = 0; exp_mp = 0; exp_ret = 0;
        check("rst2_halted", halted, 0);
        check("rst2_stop_stat", stop_stat, AOK);
        check("rst2_state", state_dbg, 0);
        check_cnts("rst2");
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("rst2_cyc%0d", k), cyc_cnt, k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
